// File: rtl/go_debounce_pkg.sv
// Shared definitions for the Go push-button conditioner: one-hot state
// encodings, the state type and the board-default debounce length.
package go_debounce_pkg;

    // One-hot state encodings.
    localparam logic [3:0] S_LO   = 4'b0001;
    localparam logic [3:0] S_RISE = 4'b0010;
    localparam logic [3:0] S_HI   = 4'b0100;
    localparam logic [3:0] S_FALL = 4'b1000;

    typedef enum logic [3:0] {
        ST_LO   = S_LO,
        ST_RISE = S_RISE,
        ST_HI   = S_HI,
        ST_FALL = S_FALL
    } state_e;

    // 10 ms of stable input at the 50 MHz board clock.
    localparam int DB_CYCLES_50MHZ = 500000;

    // True while a candidate edge is being qualified.
    function automatic logic is_busy(input state_e st);
        return (st == ST_RISE) || (st == ST_FALL);
    endfunction

endpackage

// File: rtl/go_debounce_btn_sync.sv
// Multi-flop synchroniser for an asynchronous board button. All stages
// clear on synchronous reset; the last stage is the only usable output.
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw level one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    end

    // Chain registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/go_debounce.sv
// Debounced Go button: synchroniser, edge-qualification FSM and counter,
// registered level plus optional single-cycle edge pulses.
// Build option: define GO_DEBOUNCE_EDGE_OUT_EN to implement go_rise/go_fall;
// without it both ports are tied low and no edge registers exist.
//
// state  | meaning
// S_LO   | go low, input stable low
// S_RISE | go low, counting consecutive high samples
// S_HI   | go high, input stable high
// S_FALL | go high, counting consecutive low samples
module go_debounce
    import go_debounce_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_50MHZ,
    parameter int CNT_W       = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic go,
    output logic go_rise,
    output logic go_fall,
    output logic db_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go_q, go_d;
    logic             accept_rise, accept_fall;

    btn_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn_sync (
        .clk  (clk),
        .rst  (rst),
        .d_in (btn_raw),
        .q_out(s)
    );

    // The edge that moves go is the terminal count of a qualification run.
    assign accept_rise = (state_q == ST_RISE) && s && (cnt_q == CNT_LAST);
    assign accept_fall = (state_q == ST_FALL) && !s && (cnt_q == CNT_LAST);

    // Next-state, counter and level logic; any bounce back aborts the run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_d    = go_q;
        case (state_q)
            ST_LO: begin
                if (s) begin
                    state_d = ST_RISE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RISE: begin
                if (!s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    go_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!s) begin
                    state_d = ST_FALL;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_FALL: begin
                if (s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    go_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // Corrupted encoding: park low silently.
                state_d = ST_LO;
                go_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and go level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
        end
    end

    assign go      = go_q;
    assign db_busy = is_busy(state_q);

`ifdef GO_DEBOUNCE_EDGE_OUT_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulses coincide with the first cycle of the new go level.
    always_comb begin
        rise_d = accept_rise;
        fall_d = accept_fall;
    end

    // Edge pulse registers; reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign go_rise = rise_q;
    assign go_fall = fall_q;
`else
    logic unused_accept;
    assign unused_accept = accept_rise ^ accept_fall;
    assign go_rise = 1'b0;
    assign go_fall = 1'b0;
`endif

endmodule

// File: tb/tb_go_debounce.sv
// Directed bench for go_debounce with DB_CYCLES=4, SYNC_STAGES=2.
module tb_go_debounce;
    import go_debounce_pkg::*;

`ifdef GO_DEBOUNCE_EDGE_OUT_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic go, go_rise, go_fall, db_busy;

    int checks = 0;
    int failures = 0;

    go_debounce #(
        .DB_CYCLES  (4),
        .CNT_W      (3),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .go     (go),
        .go_rise(go_rise),
        .go_fall(go_fall),
        .db_busy(db_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic b;
        logic e_go;
        logic e_rise;
        logic e_fall;
        logic e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic g,
                       input logic ri, input logic f, input logic bz);
        vec_t v;
        v.r = r; v.b = b; v.e_go = g; v.e_rise = ri; v.e_fall = f; v.e_busy = bz;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic b);
        rst = r;
        btn_raw = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs(input logic g, input logic ri, input logic f, input logic bz);
        return int'({g, ri, f, bz});
    endfunction

    initial begin
        // Reset held with button pressed, then release and qualify the press.
        add(1,1, 0,0,0,0);
        add(1,1, 0,0,0,0);
        add(0,1, 0,0,0,0);
        add(0,1, 0,0,0,0);
        add(0,1, 0,0,0,1);
        add(0,1, 0,0,0,1);
        add(0,1, 0,0,0,1);
        add(0,1, 1,1,0,0);
        add(0,1, 1,0,0,0);
        add(0,1, 1,0,0,0);
        // Clean release.
        add(0,0, 1,0,0,0);
        add(0,0, 1,0,0,0);
        add(0,0, 1,0,0,1);
        add(0,0, 1,0,0,1);
        add(0,0, 1,0,0,1);
        add(0,0, 0,0,1,0);
        add(0,0, 0,0,0,0);
        add(0,0, 0,0,0,0);
        // Clean press.
        add(0,1, 0,0,0,0);
        add(0,1, 0,0,0,0);
        add(0,1, 0,0,0,1);
        add(0,1, 0,0,0,1);
        add(0,1, 0,0,0,1);
        add(0,1, 1,1,0,0);
        add(0,1, 1,0,0,0);
        // Release back to low.
        add(0,0, 1,0,0,0);
        add(0,0, 1,0,0,0);
        add(0,0, 1,0,0,1);
        add(0,0, 1,0,0,1);
        add(0,0, 1,0,0,1);
        add(0,0, 0,0,1,0);
        add(0,0, 0,0,0,0);
        // Bounce: high 3, low 1, then steady high.
        add(0,1, 0,0,0,0);
        add(0,1, 0,0,0,0);
        add(0,1, 0,0,0,1);
        add(0,0, 0,0,0,1);
        add(0,1, 0,0,0,1);
        add(0,1, 0,0,0,0);
        add(0,1, 0,0,0,1);
        add(0,1, 0,0,0,1);
        add(0,1, 0,0,0,1);
        add(0,1, 1,1,0,0);
        add(0,1, 1,0,0,0);
        // Release to leave the design low for the hand sequences.
        add(0,0, 1,0,0,0);
        add(0,0, 1,0,0,0);
        add(0,0, 1,0,0,1);
        add(0,0, 1,0,0,1);
        add(0,0, 1,0,0,1);
        add(0,0, 0,0,1,0);
        add(0,0, 0,0,0,0);

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].b);
            chk($sformatf("vec%0d{go,rise,fall,busy}", i),
                outs(go, go_rise, go_fall, db_busy),
                outs(vecs[i].e_go, vecs[i].e_rise & EDGE_EN,
                     vecs[i].e_fall & EDGE_EN, vecs[i].e_busy));
        end

        // Boundary: three high samples of s are rejected.
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            chk($sformatf("short3_hi%0d go", i), int'(go), 0);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0);
            chk($sformatf("short3_lo%0d go", i), int'(go), 0);
            chk($sformatf("short3_lo%0d rise", i), int'(go_rise), 0);
        end
        chk("short3 busy idle", int'(db_busy), 0);

        // Boundary: exactly four high samples are accepted.
        for (int i = 0; i < 4; i++) begin
            step(0, 1);
            chk($sformatf("exact4_e%0d go", i), int'(go), 0);
        end
        step(0, 0);
        chk("exact4_e4 go", int'(go), 0);
        step(0, 0);
        chk("exact4_e5 {go,rise,fall,busy}", outs(go, go_rise, go_fall, db_busy),
            outs(1, EDGE_EN, 0, 0));
        step(0, 0);
        chk("exact4_e6 {go,rise,fall,busy}", outs(go, go_rise, go_fall, db_busy),
            outs(1, 0, 0, 1));
        step(0, 0);
        step(0, 0);
        chk("exact4_e8 go", int'(go), 1);
        step(0, 0);
        chk("exact4_e9 {go,rise,fall,busy}", outs(go, go_rise, go_fall, db_busy),
            outs(0, 0, EDGE_EN, 0));
        step(0, 0);
        chk("exact4_e10 fall", int'(go_fall), 0);
        step(0, 0);

        // Reset in the middle of a rising qualification.
        for (int i = 0; i < 4; i++) step(0, 1);
        chk("midq cnt before rst", int'(dut.cnt_q), 2);
        chk("midq busy before rst", int'(db_busy), 1);
        step(1, 1);
        chk("midq state", int'(dut.state_q), int'(S_LO));
        chk("midq cnt", int'(dut.cnt_q), 0);
        chk("midq {go,rise,fall,busy}", outs(go, go_rise, go_fall, db_busy), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1);
            chk($sformatf("post_rst_e%0d go", i), int'(go), 0);
        end
        chk("post_rst_e4 busy", int'(db_busy), 1);
        step(0, 1);
        chk("post_rst_e5 {go,rise,fall,busy}", outs(go, go_rise, go_fall, db_busy),
            outs(1, EDGE_EN, 0, 0));
        step(0, 1);
        chk("post_rst_e6 {go,rise}", outs(go, go_rise, 0, 0), outs(1, 0, 0, 0));

        // Reset while go is high: go drops without a fall pulse.
        step(1, 1);
        chk("rst_hi {go,rise,fall,busy}", outs(go, go_rise, go_fall, db_busy), 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0);
            chk($sformatf("rst_hi_after%0d {go,fall}", i),
                outs(go, 0, go_fall, 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/go_debounce.md
# go_debounce

Push-button conditioner feeding the `Go` input of the ALU toggle controller. It synchronises the raw mechanical button to `clk` and filters contact bounce with a per-edge qualification counter. It then presents a clean, glitch-free level (`go`), plus optional single-cycle edge pulses. Every change on `go` is a genuine, stable press or release, so the downstream Idle/Load/Wait/Ready sequence never double-loads on bounce.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz); legal range ≥ 2.
- `CNT_W`, default 19: counter width; must satisfy 2^CNT_W > DB_CYCLES.
- `SYNC_STAGES`, default 2: synchroniser flops; legal range ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_raw`  in  1  asynchronous raw button, active-high.
- `go`  out  1  debounced button level; drives toggle controller `Go`.
- `go_rise`  out  1  one-cycle pulse on accepted press.
- `go_fall`  out  1  one-cycle pulse on accepted release.
- `db_busy`  out  1  high while a candidate edge is being qualified.

## Operation
- Synchroniser: `SYNC_STAGES` flops, all reset to 0. The last stage is `s`, the only signal the FSM sees.
- FSM uses one-hot states `S_LO`, `S_RISE`, `S_HI`, `S_FALL`. Counter `cnt` is `CNT_W` bits wide.
- `S_LO` (`go`=0):
  - `s`=1 → `S_RISE`, `cnt`←1.
- `S_RISE` (`go`=0):
  - `s`=0 → `S_LO`, `cnt`←0.
  - else if `cnt`==DB_CYCLES-1 → `S_HI`, `go`←1, `cnt`←0.
  - else `cnt`++.
- `S_HI` (`go`=1):
  - `s`=0 → `S_FALL`, `cnt`←1.
- `S_FALL` (`go`=1):
  - `s`=1 → `S_HI`, `cnt`←0.
  - else if `cnt`==DB_CYCLES-1 → `S_LO`, `go`←0, `cnt`←0.
  - else `cnt`++.
- A change is accepted only after exactly DB_CYCLES consecutive equal samples of `s`. DB_CYCLES-1 samples are rejected.
- `db_busy` = state ∈ {`S_RISE`, `S_FALL`}. It is decoded from the state register, so it is glitch-free.
- `go` is a dedicated register, not decoded combinationally.
- `go_rise`/`go_fall` are registered, set high on the same edge that changes `go`, and cleared the next cycle.
- Illegal state encoding → `S_LO` next cycle, with `go`←0 and `cnt`←0. No pulse is emitted.
- Counter never wraps: it is bounded by the DB_CYCLES-1 compare.

## Timing
- Reset values: `go`=0, `go_rise`=0, `go_fall`=0, `db_busy`=0, state `S_LO`, `cnt`=0, sync flops 0.
- Latency: call the first edge sampling the new `btn_raw` level edge 0. `go` changes after edge SYNC_STAGES+DB_CYCLES-1. The pulse is coincident with the first cycle of the new `go` level.
- Press and release latency are identical.
- Reset mid-qualification or while `go`=1: `go` drops the cycle after the `rst` edge and no `go_fall` pulse is emitted.
- If the button is held through reset, `go` re-asserts at full latency after `rst` deasserts, with a `go_rise` pulse.
- Bounce that returns to the old level before qualification completes aborts it: `cnt` is cleared and the next edge restarts the full count.
- Minimum `go` pulse width and minimum gap between pulses: DB_CYCLES cycles.

## Configuration
- Macro: `GO_DEBOUNCE_EDGE_OUT_EN`.
- Defined: `go_rise`/`go_fall` registers are implemented as specified.
- Undefined: `go_rise`/`go_fall` ports remain but are tied to 0, and no edge registers are synthesised. `go` and `db_busy` behaviour is unchanged.

## Structure
- Shared package holds:
  - the one-hot state localparams (`S_LO`=4'b0001, `S_RISE`=4'b0010, `S_HI`=4'b0100, `S_FALL`=4'b1000);
  - the default DB_CYCLES constant for the 50 MHz board clock.
- One sub-module, `btn_sync`: a parameterised SYNC_STAGES flop chain with synchronous reset, reusable for the other board buttons.
- FSM, counter and pulse logic stay in `go_debounce`.

## Test plan
All scenarios use DB_CYCLES=4 and SYNC_STAGES=2.
- Reset: assert `rst` 2 cycles with `btn_raw`=1 → all outputs 0 during and one cycle after reset. `go`=1 after edge 5 following release, with a single `go_rise`.
- Clean press: `btn_raw` 0→1 sampled at edge 0 and held → `go`=1 after edge 5, `go_rise` high for exactly that one cycle, `db_busy` high after edges 2–4.
- Bounce rejection: `btn_raw` high for 3 cycles, low 1, then high steady → no `go` change during the glitch. `go` rises 5 edges after the final rising sample.
- Boundary: `s` high for exactly 3 consecutive samples then low → `go` stays 0. Exactly 4 samples → `go`=1.
- Release: `go`=1, `btn_raw` 1→0 held → `go`=0 after edge 5 with a one-cycle `go_fall`. With the macro undefined, `go_rise`/`go_fall` stay 0 throughout.
- Reset mid-qualification: `rst` asserted while in `S_RISE` with `cnt`=2 → next cycle state `S_LO`, `cnt`=0, `go`=0, no pulse.
